// File: rtl/shift_op_counter_unit_pkg.sv
// Shared opcode and FSM state encodings for the shift/op/counter unit.
package shift_op_counter_unit_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD     = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD_DBL = 3'b001;
    localparam logic [OP_W-1:0] OP_INC      = 3'b010;
    localparam logic [OP_W-1:0] OP_DEC      = 3'b011;
    localparam logic [OP_W-1:0] OP_SHL      = 3'b100;
    localparam logic [OP_W-1:0] OP_SHR      = 3'b101;
    localparam logic [OP_W-1:0] OP_ROL      = 3'b110;
    localparam logic [OP_W-1:0] OP_CLR      = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/shift_op_counter_unit_if.sv
// Operation request/response bundle between the sequencer and the unit.
interface shift_op_counter_unit_if
    import shift_op_counter_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SHAMT_W   = 4,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 op_valid;
    logic                 op_ready;
    logic [OP_W-1:0]      op;
    logic [WIDTH-1:0]     data_in;
    logic [SHAMT_W-1:0]   shamt;
    logic                 count_clr;
    logic [WIDTH-1:0]     data_out;
    logic                 carry;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] op_count;

    modport master (
        output op_valid, op, data_in, shamt, count_clr,
        input  op_ready, data_out, carry, busy, done, op_count
    );

    modport slave (
        input  op_valid, op, data_in, shamt, count_clr,
        output op_ready, data_out, carry, busy, done, op_count
    );

endinterface

// File: rtl/shift_op_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment restarts at 1.
module shift_op_sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/shift_op_counter_unit.sv
// Programmable shift/accumulate register: single-cycle arithmetic ops and
// multi-cycle 1-bit-per-clock shifts/rotates, with a saturating op counter.
module shift_op_counter_unit
    import shift_op_counter_unit_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SHAMT_W   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_op_counter_unit_if.slave  bus
);

    logic [0:0]         state, state_nxt;
    logic [SHAMT_W-1:0] remaining, remaining_nxt;
    logic [OP_W-1:0]    op_lat, op_lat_nxt;
    logic [WIDTH-1:0]   data_q, data_nxt;
    logic               carry_q, carry_nxt;
    logic               done_q, done_nxt;
    logic               accept;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    assign accept = bus.op_valid & (state == ST_IDLE);

    // One 1-bit step of the latched shift/rotate
    always_comb begin
        step_data  = data_q;
        step_carry = carry_q;
        case (op_lat)
            OP_SHL: begin
                step_data  = {data_q[WIDTH-2:0], 1'b0};
                step_carry = data_q[WIDTH-1];
            end
            OP_SHR: begin
                step_data  = {1'b0, data_q[WIDTH-1:1]};
                step_carry = data_q[0];
            end
            OP_ROL: begin
                step_data  = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                step_carry = data_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        op_lat_nxt    = op_lat;
        data_nxt      = data_q;
        carry_nxt     = carry_q;
        done_nxt      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    done_nxt = 1'b1;
                    case (bus.op)
                        OP_LOAD: begin
                            data_nxt  = bus.data_in;
                            carry_nxt = 1'b0;
                        end
                        OP_LOAD_DBL: begin
                            data_nxt  = {bus.data_in[WIDTH-2:0], 1'b0};
                            carry_nxt = 1'b0;
                        end
                        OP_INC: begin
                            data_nxt  = data_q + WIDTH'(1);
                            carry_nxt = &data_q;
                        end
                        OP_DEC: begin
                            data_nxt  = data_q - WIDTH'(1);
                            carry_nxt = (data_q == '0);
                        end
                        OP_CLR: begin
                            data_nxt  = '0;
                            carry_nxt = 1'b0;
                        end
                        default: begin
                            // Zero-amount shifts complete at once and leave data/carry alone
                            if (bus.shamt != '0) begin
                                done_nxt      = 1'b0;
                                state_nxt     = ST_SHIFT;
                                remaining_nxt = bus.shamt;
                                op_lat_nxt    = bus.op;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                data_nxt      = step_data;
                carry_nxt     = step_carry;
                remaining_nxt = remaining - SHAMT_W'(1);
                if (remaining == SHAMT_W'(1)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            op_lat    <= OP_LOAD;
            data_q    <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            op_lat    <= op_lat_nxt;
            data_q    <= data_nxt;
            carry_q   <= carry_nxt;
            done_q    <= done_nxt;
        end
    end

    shift_op_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept),
        .clr   (bus.count_clr),
        .count (bus.op_count)
    );

    assign bus.data_out = data_q;
    assign bus.carry    = carry_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state == ST_SHIFT);
    assign bus.op_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_shift_op_counter_unit.sv
// Self-checking bench: table of ops checked against a reference model via a
// scoreboard, plus hand sequences for busy-ignore, saturation and resets.
module tb_shift_op_counter_unit;
    import shift_op_counter_unit_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_op_counter_unit_if #(.WIDTH(W), .SHAMT_W(SW), .CNT_WIDTH(CW)) bus ();

    shift_op_counter_unit #(.WIDTH(W), .SHAMT_W(SW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic [2:0] count;
        int         cycles;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] din;
        logic [3:0] sh;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    logic [7:0] m_data  = '0;
    logic       m_carry = 1'b0;
    logic [2:0] m_count = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_data = '0; m_carry = 1'b0; m_count = '0;
    endtask

    // Closed-form reference: shifts/rotates computed in one go, not stepwise
    task automatic model_op(input logic [2:0] op, input logic [7:0] d, input int n,
                            input logic clr, output exp_t e);
        logic [15:0] w;
        int k;
        case (op)
            OP_LOAD:     begin m_data = d; m_carry = 1'b0; end
            OP_LOAD_DBL: begin m_data = {d[6:0], 1'b0}; m_carry = 1'b0; end
            OP_INC:      begin m_carry = (m_data == 8'hFF); m_data = m_data + 8'd1; end
            OP_DEC:      begin m_carry = (m_data == 8'h00); m_data = m_data - 8'd1; end
            OP_CLR:      begin m_data = '0; m_carry = 1'b0; end
            OP_SHL: if (n != 0) begin
                m_carry = (n <= 8) ? m_data[8-n] : 1'b0;
                m_data  = (n >= 8) ? 8'h00 : 8'(m_data << n);
            end
            OP_SHR: if (n != 0) begin
                m_carry = (n <= 8) ? m_data[n-1] : 1'b0;
                m_data  = (n >= 8) ? 8'h00 : (m_data >> n);
            end
            default: if (n != 0) begin
                k = n % 8;
                w = {m_data, m_data};
                m_data  = w[15-k -: 8];
                m_carry = m_data[0];
            end
        endcase
        if (clr) m_count = 3'd1;
        else if (m_count != 3'd7) m_count = m_count + 3'd1;
        e.data   = m_data;
        e.carry  = m_carry;
        e.count  = m_count;
        e.cycles = (op[2] && op != OP_CLR && n != 0) ? n : 0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] d, input logic [3:0] n,
                          input logic clr);
        exp_t e, got;
        int   busy_cycles;
        model_op(op, d, int'(n), clr, e);
        sbq.push_back(e);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = op; bus.data_in = d; bus.shamt = n; bus.count_clr = clr;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.count_clr = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
        end
        chk("done_seen", 32'(bus.done), 32'd1);
        got = sbq.pop_front();
        chk("data", 32'(bus.data_out), 32'(got.data));
        chk("carry", 32'(bus.carry), 32'(got.carry));
        chk("count", 32'(bus.op_count), 32'(got.count));
        chk("busy_cycles", 32'(busy_cycles), 32'(got.cycles));
        @(negedge clk);
        chk("done_pulse_end", 32'(bus.done), 32'd0);
    endtask

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{OP_LOAD,     8'hA5, 4'd0,  8'hA5, 1'b0};
        tbl[1]  = '{OP_LOAD,     8'hFF, 4'd0,  8'hFF, 1'b0};
        tbl[2]  = '{OP_INC,      8'h00, 4'd0,  8'h00, 1'b1};
        tbl[3]  = '{OP_DEC,      8'h00, 4'd0,  8'hFF, 1'b1};
        tbl[4]  = '{OP_LOAD_DBL, 8'hC3, 4'd0,  8'h86, 1'b0};
        tbl[5]  = '{OP_LOAD,     8'h81, 4'd0,  8'h81, 1'b0};
        tbl[6]  = '{OP_SHL,      8'h00, 4'd3,  8'h08, 1'b0};
        tbl[7]  = '{OP_LOAD,     8'h81, 4'd0,  8'h81, 1'b0};
        tbl[8]  = '{OP_ROL,      8'h00, 4'd9,  8'h03, 1'b1};
        tbl[9]  = '{OP_SHR,      8'h00, 4'd0,  8'h03, 1'b1};
        tbl[10] = '{OP_LOAD,     8'hFF, 4'd0,  8'hFF, 1'b0};
        tbl[11] = '{OP_SHR,      8'h00, 4'd15, 8'h00, 1'b0};
        tbl[12] = '{OP_DEC,      8'h00, 4'd0,  8'hFF, 1'b1};
        tbl[13] = '{OP_CLR,      8'h00, 4'd0,  8'h00, 1'b0};
        tbl[14] = '{OP_INC,      8'h00, 4'd0,  8'h01, 1'b0};

        bus.op_valid = 1'b0; bus.op = OP_LOAD; bus.data_in = '0; bus.shamt = '0; bus.count_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_count", 32'(bus.op_count), 32'd0);
        chk("rst_ready", 32'(bus.op_ready), 32'd1);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].op, tbl[i].din, tbl[i].sh, 1'b0);
            chk("tbl_data", 32'(bus.data_out), 32'(tbl[i].ed));
            chk("tbl_carry", 32'(bus.carry), 32'(tbl[i].ec));
        end

        // Mid-cycle async reset pulse
        @(posedge clk); #2 rst = 1'b1; #1;
        chk("async_rst_data", 32'(bus.data_out), 32'd0);
        chk("async_rst_carry", 32'(bus.carry), 32'd0);
        chk("async_rst_count", 32'(bus.op_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();

        // SHL by 3 with op_valid held (as CLR) during busy: must be ignored
        run_op(OP_LOAD, 8'h81, 4'd0, 1'b0);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = OP_SHL; bus.shamt = 4'd3;
        @(negedge clk);
        bus.op = OP_CLR;
        chk("shl_busy0", 32'(bus.busy), 32'd1);
        chk("shl_ready0", 32'(bus.op_ready), 32'd0);
        chk("shl_hold", 32'(bus.data_out), 32'h81);
        chk("shl_cnt_acc", 32'(bus.op_count), 32'd2);
        @(negedge clk);
        chk("shl_step1", 32'(bus.data_out), 32'h02);
        chk("shl_carry1", 32'(bus.carry), 32'd1);
        @(negedge clk);
        chk("shl_step2", 32'(bus.data_out), 32'h04);
        chk("shl_cnt_busy", 32'(bus.op_count), 32'd2);
        chk("shl_done_early", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("shl_step3", 32'(bus.data_out), 32'h08);
        chk("shl_done", 32'(bus.done), 32'd1);
        chk("shl_busy3", 32'(bus.busy), 32'd0);
        chk("shl_carry3", 32'(bus.carry), 32'd0);
        m_data = 8'h08; m_carry = 1'b0; m_count = 3'd2;

        // Saturation: 9 back-to-back INCs
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = OP_INC;
        repeat (9) @(negedge clk);
        bus.op_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_t e;
            model_op(OP_INC, 8'h00, 0, 1'b0, e);
        end
        chk("sat_count", 32'(bus.op_count), 32'd7);
        chk("sat_data", 32'(bus.data_out), 32'(m_data));

        run_op(OP_LOAD, 8'h11, 4'd0, 1'b1);
        @(negedge clk);
        bus.count_clr = 1'b1;
        @(negedge clk);
        bus.count_clr = 1'b0;
        chk("clr_alone", 32'(bus.op_count), 32'd0);
        chk("clr_keeps_data", 32'(bus.data_out), 32'h11);
        m_count = '0;

        // Reset during SHL by 5, after step 2
        run_op(OP_LOAD, 8'h3C, 4'd0, 1'b0);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = OP_SHL; bus.shamt = 4'd5;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_shift_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_data", 32'(bus.data_out), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(bus.done), 32'd0);
        end
        run_op(OP_LOAD, 8'h5A, 4'd0, 1'b0);
        run_op(OP_SHR, 8'h00, 4'd2, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
